burst_master: RTL and testbench
===============================

Name: burst_master

Overview:
- Bus master that sits directly upstream of the memory slave.
- Accepts one read or write burst command at a time from a host/testbench port.
- Drives the slave's packed read-address (IN), write-address (AWIN), write-data and response channels.
- Returns read beats and a completion/status pulse; a write-data FIFO decouples host pushes from the W channel.

Parameters:
TIMEOUT, 64, cycles waited in any slave-handshake state before aborting (counter 8 bits, 1..255)
FIFO_DEPTH, 16, write-data FIFO entries (fixed power of 2; count width 5)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  0 while rst high, else 1 exactly when state==IDLE
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  8  start byte address
cmd_len  in  4  beats minus one (0..15)
cmd_id  in  4  transaction id
wfifo_push  in  1  push wfifo_data
wfifo_data  in  8  write byte
wfifo_full  out  1  FIFO holds FIFO_DEPTH entries
rdata  out  8  read byte
rdata_valid  out  1  one-cycle pulse per accepted read beat
rdata_err  out  1  slave error flag for that beat
done  out  1  one-cycle completion pulse
done_err  out  1  status with done
done_timeout  out  1  timeout abort flag with done
done_id  out  4  id with done
ARVALID  out  1  read address valid
ARREADY  in  1  slave accepted read address
IN  out  16  {addr[7:0], len[3:0], id[3:0]}
RVALID  in  1  read beat valid
RREADY  out  1  master accepts beat
RLAST  in  1  final read beat
OUT  in  9  {data[7:0], err}
AWVALID  out  1  write address valid
AWREADY  in  1  slave accepted write address
AWIN  out  12  {addr[7:0], id[3:0]}
WVALID  out  1  write beat valid
WREADY  in  1  slave accepts beat
WLAST  out  1  final write beat
WDATA  out  8  write byte (FIFO head)
BVALID  in  1  write response valid
BREADY  out  1  master accepts response
BRESP  in  5  {err, id[3:0]}

Behaviour:
- Reset (async): state IDLE; FIFO emptied; every registered output 0 (ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY, IN, AWIN, rdata*, done*); timeout counter 0.
- Command accepted when cmd_valid && cmd_ready at posedge; fields latched into cmd regs; the err accumulator clears.
- States:
  - IDLE: on accept go to AR (read), or WAIT_DATA (write).
  - WAIT_DATA: stay until FIFO count >= cmd_len+1, then AW. No timeout here.
  - AR: ARVALID=1, IN driven. On ARREADY, deassert ARVALID the next cycle (the slave advances only once ARVALID is low) and go to R.
  - R: RREADY=1. Each RVALID&&RREADY posedge gives, next cycle:
    - rdata=OUT[8:1], rdata_err=OUT[0], rdata_valid pulse;
    - err accumulator |= OUT[0];
    - beat count+1.
    - Beat with RLAST=1 -> DONE. More than cmd_len+1 beats before RLAST sets err.
  - AW: AWVALID=1, AWIN driven. On AWREADY, drop AWVALID and go to W.
  - W: WVALID=1, WDATA=FIFO head, WLAST=1 on beat index cmd_len. Each WVALID&&WREADY pops the FIFO. After the last beat, deassert WVALID/WLAST and go to B.
  - B: BREADY=1. On BVALID: err |= BRESP[4] | (BRESP[3:0]!=cmd_id); BREADY drops next cycle; go to DONE.
  - DONE: one cycle; done=1, done_err=err, done_id=cmd_id; then IDLE. The slave's idle/delay gap is absorbed by ARREADY/AWREADY waits.
- Timeout: counter resets on state entry and on every handshake in AR/R/AW/W/B. Reaching TIMEOUT -> all slave-side valids/readies low, go to DONE with done_err=1, done_timeout=1. In W, unsent beats for that burst are flushed from the FIFO.
- FIFO:
  - push when full: ignored, data dropped.
  - push and pop in the same cycle: count unchanged.
  - Pointers wrap mod FIFO_DEPTH; pushes allowed in any state.
- Reset mid-burst: all channel outputs drop immediately (async); the slave is reset by the same rst.

Test Plan:
- Write addr 0x10, len 3, id 5, bytes A1..A4 pushed first -> AWIN=0x105; 4 W beats with WLAST on the 4th; BRESP=0x05 -> done, done_err=0, done_id=5.
- Read addr 0x10, len 3, id 5 after the write -> IN=0x1035; rdata A1,A2,A3,A4 with rdata_err=0; done_err=0.
- Read with OUT=0x001 on a beat -> rdata_err=1, done_err=1; BRESP=0x13 for write id 3 -> done_err=1.
- Write len 7 with only 5 bytes pushed -> stays in WAIT_DATA, AWVALID=0; push 3 more -> burst proceeds.
- ARREADY held 0 with TIMEOUT=8 -> ARVALID falls after 8 cycles; done, done_timeout=1, done_id=cmd_id.
- 17 pushes with no pops -> wfifo_full=1 after 16, 17th dropped; rst mid-W -> WVALID=0 the same cycle, FIFO empty.

Source files
------------

// File: rtl/burst_master_if.sv
// Slave-side bus of burst_master: packed read-address, read-data, write-address, write-data, response.
// Latency: none, wiring only.
// Backpressure: every channel is valid/ready; the master modport owns the valids of AR/AW/W and the readies of R/B.
interface burst_master_if;
    logic        ARVALID;
    logic        ARREADY;
    logic [15:0] IN;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [8:0]  OUT;
    logic        AWVALID;
    logic        AWREADY;
    logic [11:0] AWIN;
    logic        WVALID;
    logic        WREADY;
    logic        WLAST;
    logic [7:0]  WDATA;
    logic        BVALID;
    logic        BREADY;
    logic [4:0]  BRESP;

    modport master (
        output ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WLAST, WDATA, BREADY,
        input  ARREADY, RVALID, RLAST, OUT, AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WLAST, WDATA, BREADY,
        output ARREADY, RVALID, RLAST, OUT, AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/burst_master.sv
// Single-outstanding burst master: host command in, AR/R or AW/W/B on the slave, done/status pulse out.
// Latency: channel outputs are registered (one cycle after the causing edge); done follows the last handshake by one cycle.
// Backpressure: cmd_ready only in IDLE; slave stalls bounded by TIMEOUT; write FIFO drops pushes while full.
module burst_master #(
    parameter int TIMEOUT    = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic [3:0] cmd_id,
    input  logic       wfifo_push,
    input  logic [7:0] wfifo_data,
    output logic       wfifo_full,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       rdata_err,
    output logic       done,
    output logic       done_err,
    output logic       done_timeout,
    output logic [3:0] done_id,
    burst_master_if.master bus
);

    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DATA, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // latched command and burst progress
    logic [3:0]      r_cmd_len;
    logic [3:0]      r_cmd_id;
    logic            r_err;
    logic [4:0]      r_beat;
    logic [3:0]      r_wbeat;
    logic [7:0]      r_tcnt;

    // write-data FIFO
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    // registered outputs
    logic            r_arvalid;
    logic            r_rready;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_wlast;
    logic            r_bready;
    logic [15:0]     r_in;
    logic [11:0]     r_awin;
    logic [7:0]      r_rdata;
    logic            r_rdata_valid;
    logic            r_rdata_err;
    logic            r_done;
    logic            r_done_err;
    logic            r_done_timeout;
    logic [3:0]      r_done_id;

    logic            w_accept;
    logic            w_push;
    logic            w_hs;
    logic            w_tmo;
    logic            w_rd_fire;
    logic            w_err_nxt;
    logic [4:0]      w_beat_nxt;
    logic [3:0]      w_wbeat_nxt;
    logic [CW-1:0]   w_pop_cnt;
    logic [CW-1:0]   w_need;
    logic            w_timed;

    assign cmd_ready  = ~rst && (r_state == S_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign wfifo_full = (r_count == CW'(FIFO_DEPTH));
    assign w_push     = wfifo_push && !wfifo_full;
    assign w_need     = CW'(r_cmd_len) + CW'(1);
    assign w_timed    = (r_state == S_AR) || (r_state == S_R) || (r_state == S_AW) ||
                        (r_state == S_W)  || (r_state == S_B);

    assign bus.ARVALID = r_arvalid;
    assign bus.IN      = r_in;
    assign bus.RREADY  = r_rready;
    assign bus.AWVALID = r_awvalid;
    assign bus.AWIN    = r_awin;
    assign bus.WVALID  = r_wvalid;
    assign bus.WLAST   = r_wlast;
    assign bus.WDATA   = r_mem[r_rd_ptr];
    assign bus.BREADY  = r_bready;

    assign rdata        = r_rdata;
    assign rdata_valid  = r_rdata_valid;
    assign rdata_err    = r_rdata_err;
    assign done         = r_done;
    assign done_err     = r_done_err;
    assign done_timeout = r_done_timeout;
    assign done_id      = r_done_id;

    // next state, handshake detection, error accumulation, FIFO pop amount
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_hs        = 1'b0;
        w_tmo       = 1'b0;
        w_rd_fire   = 1'b0;
        w_beat_nxt  = r_beat;
        w_wbeat_nxt = r_wbeat;
        w_pop_cnt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_err_nxt   = 1'b0;
                    w_beat_nxt  = 5'd0;
                    w_wbeat_nxt = 4'd0;
                    w_state_nxt = cmd_write ? S_WAIT_DATA : S_AR;
                end
            end
            S_WAIT_DATA: begin
                if (r_count >= w_need) w_state_nxt = S_AW;
            end
            S_AR: begin
                w_hs = bus.ARREADY;
                if (w_hs) w_state_nxt = S_R;
            end
            S_R: begin
                w_hs = bus.RVALID;
                if (w_hs) begin
                    w_rd_fire  = 1'b1;
                    // a beat beyond len+1 without RLAST is an overrun
                    w_err_nxt  = r_err | bus.OUT[0] | (r_beat > {1'b0, r_cmd_len});
                    w_beat_nxt = (r_beat == 5'h1F) ? r_beat : r_beat + 5'd1;
                    if (bus.RLAST) w_state_nxt = S_DONE;
                end
            end
            S_AW: begin
                w_hs = bus.AWREADY;
                if (w_hs) w_state_nxt = S_W;
            end
            S_W: begin
                w_hs = bus.WREADY;
                if (w_hs) begin
                    w_pop_cnt   = CW'(1);
                    w_wbeat_nxt = r_wbeat + 4'd1;
                    if (r_wbeat == r_cmd_len) w_state_nxt = S_B;
                end
            end
            S_B: begin
                w_hs = bus.BVALID;
                if (w_hs) begin
                    w_err_nxt   = r_err | bus.BRESP[4] | (bus.BRESP[3:0] != r_cmd_id);
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // a handshake in the final cycle still wins over the abort
        if (w_timed && !w_hs && (r_tcnt == TMO_LAST)) begin
            w_tmo       = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
            // drop the unsent remainder of this burst so the next one starts clean
            if (r_state == S_W) w_pop_cnt = CW'(r_cmd_len) - CW'(r_wbeat) + CW'(1);
        end
    end

    // state, command latch, progress counters and the stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cmd_len <= 4'd0;
            r_cmd_id  <= 4'd0;
            r_err     <= 1'b0;
            r_beat    <= 5'd0;
            r_wbeat   <= 4'd0;
            r_tcnt    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            r_beat  <= w_beat_nxt;
            r_wbeat <= w_wbeat_nxt;
            if (w_accept) begin
                r_cmd_len <= cmd_len;
                r_cmd_id  <= cmd_id;
            end
            if ((w_state_nxt != r_state) || w_hs) r_tcnt <= 8'd0;
            else if (r_tcnt != 8'hFF)             r_tcnt <= r_tcnt + 8'd1;
        end
    end

    // channel outputs follow the state being entered, so they are glitch-free registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_wlast        <= 1'b0;
            r_bready       <= 1'b0;
            r_in           <= 16'd0;
            r_awin         <= 12'd0;
            r_rdata        <= 8'd0;
            r_rdata_valid  <= 1'b0;
            r_rdata_err    <= 1'b0;
            r_done         <= 1'b0;
            r_done_err     <= 1'b0;
            r_done_timeout <= 1'b0;
            r_done_id      <= 4'd0;
        end else begin
            r_arvalid      <= (w_state_nxt == S_AR);
            r_rready       <= (w_state_nxt == S_R);
            r_awvalid      <= (w_state_nxt == S_AW);
            r_wvalid       <= (w_state_nxt == S_W);
            r_wlast        <= (w_state_nxt == S_W) && (w_wbeat_nxt == r_cmd_len);
            r_bready       <= (w_state_nxt == S_B);
            if (w_accept && !cmd_write) r_in   <= {cmd_addr, cmd_len, cmd_id};
            if (w_accept &&  cmd_write) r_awin <= {cmd_addr, cmd_id};
            r_rdata_valid  <= w_rd_fire;
            r_rdata_err    <= w_rd_fire & bus.OUT[0];
            if (w_rd_fire) r_rdata <= bus.OUT[8:1];
            r_done         <= (w_state_nxt == S_DONE);
            r_done_err     <= (w_state_nxt == S_DONE) & w_err_nxt;
            r_done_timeout <= w_tmo;
            r_done_id      <= (w_state_nxt == S_DONE) ? r_cmd_id : 4'd0;
        end
    end

    // FIFO pointers and occupancy; pushes are accepted in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop_cnt);
            r_count  <= r_count + CW'(w_push) - w_pop_cnt;
        end
    end

    // FIFO storage needs no reset; emptiness is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wfifo_data;
    end

endmodule

// File: tb/tb_burst_master.sv
module tb_burst_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid, cmd_write;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len, cmd_id;
    logic       wfifo_push;
    logic [7:0] wfifo_data;
    logic       wfifo_full;
    logic [7:0] rdata;
    logic       rdata_valid, rdata_err;
    logic       done, done_err, done_timeout;
    logic [3:0] done_id;

    burst_master_if bus();

    burst_master #(.TIMEOUT(8), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wfifo_push(wfifo_push), .wfifo_data(wfifo_data), .wfifo_full(wfifo_full),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_err(rdata_err),
        .done(done), .done_err(done_err), .done_timeout(done_timeout), .done_id(done_id),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] wq[$];
    logic [7:0] rd_dat[16];
    logic       rd_e[16];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wfifo_data = d;
        wfifo_push = 1'b1;
        if (wq.size() < 16) wq.push_back(d);
        tick;
        wfifo_push = 1'b0;
    endtask

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] l, input logic [3:0] id);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin tick; n++; end
        chk("cmd_ready_wait", 32'(n < 50), 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id;
        tick;
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_aw;
        int n;
        n = 0;
        while (bus.AWVALID !== 1'b1 && n < 40) begin tick; n++; end
        chk("aw_wait", 32'(n < 40), 32'd1);
    endtask

    task automatic run_write(input logic [3:0] l, input logic [3:0] id, input logic [4:0] bresp,
                             input logic exp_err, input logic [11:0] exp_awin);
        logic [7:0] e;
        wait_aw;
        chk("awin", 32'(bus.AWIN), 32'(exp_awin));
        bus.AWREADY = 1'b1; tick; bus.AWREADY = 1'b0;
        chk("awvalid_drop", 32'(bus.AWVALID), 32'd0);
        bus.WREADY = 1'b1;
        for (int i = 0; i <= int'(l); i++) begin
            e = (wq.size() > 0) ? wq.pop_front() : 8'h00;
            chk("wvalid", 32'(bus.WVALID), 32'd1);
            chk("wdata", 32'(bus.WDATA), 32'(e));
            chk("wlast", 32'(bus.WLAST), 32'(i == int'(l)));
            tick;
        end
        bus.WREADY = 1'b0;
        chk("wvalid_drop", 32'(bus.WVALID), 32'd0);
        chk("wlast_drop", 32'(bus.WLAST), 32'd0);
        chk("bready", 32'(bus.BREADY), 32'd1);
        bus.BVALID = 1'b1; bus.BRESP = bresp; tick; bus.BVALID = 1'b0;
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_done_err", 32'(done_err), 32'(exp_err));
        chk("wr_done_id", 32'(done_id), 32'(id));
        chk("wr_done_to", 32'(done_timeout), 32'd0);
        chk("bready_drop", 32'(bus.BREADY), 32'd0);
        tick;
        chk("wr_done_pulse", 32'(done), 32'd0);
    endtask

    task automatic run_read(input int nb, input logic [3:0] id, input logic exp_err, input logic [15:0] exp_in);
        chk("arvalid", 32'(bus.ARVALID), 32'd1);
        chk("in", 32'(bus.IN), 32'(exp_in));
        bus.ARREADY = 1'b1; tick; bus.ARREADY = 1'b0;
        chk("arvalid_drop", 32'(bus.ARVALID), 32'd0);
        chk("rready", 32'(bus.RREADY), 32'd1);
        for (int i = 0; i < nb; i++) begin
            bus.RVALID = 1'b1;
            bus.OUT    = {rd_dat[i], rd_e[i]};
            bus.RLAST  = (i == nb - 1);
            tick;
            chk("rdata_valid", 32'(rdata_valid), 32'd1);
            chk("rdata", 32'(rdata), 32'(rd_dat[i]));
            chk("rdata_err", 32'(rdata_err), 32'(rd_e[i]));
        end
        bus.RVALID = 1'b0; bus.RLAST = 1'b0;
        chk("rd_done", 32'(done), 32'd1);
        chk("rd_done_err", 32'(done_err), 32'(exp_err));
        chk("rd_done_id", 32'(done_id), 32'(id));
        chk("rready_drop", 32'(bus.RREADY), 32'd0);
        tick;
        chk("rd_done_pulse", 32'(done), 32'd0);
        chk("rdata_valid_pulse", 32'(rdata_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        wfifo_push = 0; wfifo_data = 0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RLAST = 0; bus.OUT = 0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;

        // reset state
        tick; tick;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_arvalid", 32'(bus.ARVALID), 32'd0);
        chk("rst_awvalid", 32'(bus.AWVALID), 32'd0);
        chk("rst_wvalid", 32'(bus.WVALID), 32'd0);
        chk("rst_in", 32'(bus.IN), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_full", 32'(wfifo_full), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        tick;

        // write 0x10 len 3 id 5, data pushed first
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        send_cmd(1'b1, 8'h10, 4'd3, 4'd5);
        run_write(4'd3, 4'd5, 5'h05, 1'b0, 12'h105);

        // read back the same burst
        rd_dat[0] = 8'hA1; rd_dat[1] = 8'hA2; rd_dat[2] = 8'hA3; rd_dat[3] = 8'hA4;
        for (int i = 0; i < 4; i++) rd_e[i] = 1'b0;
        send_cmd(1'b0, 8'h10, 4'd3, 4'd5);
        run_read(4, 4'd5, 1'b0, 16'h1035);

        // read with a slave error flag on the second beat (OUT = 0x001)
        rd_dat[0] = 8'h55; rd_e[0] = 1'b0;
        rd_dat[1] = 8'h00; rd_e[1] = 1'b1;
        send_cmd(1'b0, 8'h20, 4'd1, 4'd2);
        run_read(2, 4'd2, 1'b1, 16'h2012);

        // write response with the error bit set
        push(8'h77);
        send_cmd(1'b1, 8'h24, 4'd0, 4'd3);
        run_write(4'd0, 4'd3, 5'h13, 1'b1, 12'h243);

        // write response carrying the wrong id
        push(8'h78);
        send_cmd(1'b1, 8'h28, 4'd0, 4'd4);
        run_write(4'd0, 4'd4, 5'h05, 1'b1, 12'h284);

        // read overrun: len 0 but RLAST only on the second beat
        rd_dat[0] = 8'h61; rd_e[0] = 1'b0;
        rd_dat[1] = 8'h62; rd_e[1] = 1'b0;
        send_cmd(1'b0, 8'h2C, 4'd0, 4'd6);
        run_read(2, 4'd6, 1'b1, 16'h2C06);

        // len 7 write stalls in WAIT_DATA with only 5 bytes queued
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        send_cmd(1'b1, 8'h50, 4'd7, 4'd2);
        for (int i = 0; i < 12; i++) tick;
        chk("stall_awvalid", 32'(bus.AWVALID), 32'd0);
        chk("stall_done", 32'(done), 32'd0);
        chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 5; i < 8; i++) push(8'hC0 + 8'(i));
        run_write(4'd7, 4'd2, 5'h02, 1'b0, 12'h502);

        // AR timeout: ARREADY never rises, TIMEOUT = 8
        send_cmd(1'b0, 8'h30, 4'd0, 4'd9);
        n = 0;
        while (bus.ARVALID === 1'b1 && n < 20) begin n++; tick; end
        chk("ar_tmo_cycles", 32'(n), 32'd8);
        chk("ar_tmo_done", 32'(done), 32'd1);
        chk("ar_tmo_flag", 32'(done_timeout), 32'd1);
        chk("ar_tmo_err", 32'(done_err), 32'd1);
        chk("ar_tmo_id", 32'(done_id), 32'd9);
        chk("ar_tmo_rready", 32'(bus.RREADY), 32'd0);
        tick;
        chk("ar_tmo_pulse", 32'(done_timeout), 32'd0);

        // W timeout flushes both unsent bytes of the burst
        push(8'hB1); push(8'hB2);
        send_cmd(1'b1, 8'h70, 4'd1, 4'd8);
        wait_aw;
        bus.AWREADY = 1'b1; tick; bus.AWREADY = 1'b0;
        n = 0;
        while (bus.WVALID === 1'b1 && n < 20) begin n++; tick; end
        chk("w_tmo_cycles", 32'(n), 32'd8);
        chk("w_tmo_flag", 32'(done_timeout), 32'd1);
        chk("w_tmo_id", 32'(done_id), 32'd8);
        wq.delete();
        push(8'h5A);
        send_cmd(1'b1, 8'h74, 4'd0, 4'd1);
        run_write(4'd0, 4'd1, 5'h01, 1'b0, 12'h741);

        // fill to 16, 17th push dropped
        for (int i = 0; i < 15; i++) push(8'h80 + 8'(i));
        chk("full_at_15", 32'(wfifo_full), 32'd0);
        push(8'h8F);
        chk("full_at_16", 32'(wfifo_full), 32'd1);
        push(8'hEE);
        chk("full_after_17", 32'(wfifo_full), 32'd1);
        send_cmd(1'b1, 8'h60, 4'd15, 4'd1);
        run_write(4'd15, 4'd1, 5'h01, 1'b0, 12'h601);
        chk("empty_after_drain", 32'(wfifo_full), 32'd0);

        // reset in the middle of W
        push(8'h11); push(8'h22);
        send_cmd(1'b1, 8'h40, 4'd1, 4'd6);
        wait_aw;
        bus.AWREADY = 1'b1; tick; bus.AWREADY = 1'b0;
        chk("pre_rst_wvalid", 32'(bus.WVALID), 32'd1);
        chk("pre_rst_wdata", 32'(bus.WDATA), 32'h11);
        rst = 1'b1;
        #1;
        chk("rst_mid_wvalid", 32'(bus.WVALID), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
        tick;
        rst = 1'b0;
        wq.delete();
        push(8'h3C);
        send_cmd(1'b1, 8'h50, 4'd0, 4'd7);
        run_write(4'd0, 4'd7, 5'h07, 1'b0, 12'h507);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
